// File: rtl/clic_core_bridge_pkg.sv
// Shared CLIC constants and the bridge FSM state type.
package clic_core_bridge_pkg;

    localparam int CLIC_INTCTLBITS = 8;
    localparam int CLIC_PRIV_W     = 2;
    localparam int CLIC_N_SOURCE   = 256;
    localparam int CLIC_SRC_W      = $clog2(CLIC_N_SOURCE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK,
        ST_KILL,
        ST_GAP
    } bridge_state_e;

endpackage

// File: rtl/clic_core_bridge_if.sv
// Bundle of the CLIC-side and core-side handshake signals around the bridge.
interface clic_core_bridge_if
    import clic_core_bridge_pkg::*;
#(
    parameter int SRC_W = CLIC_SRC_W
) ();
    logic                       irq_valid_i;
    logic [SRC_W-1:0]           irq_id_i;
    logic [CLIC_INTCTLBITS-1:0] irq_level_i;
    logic                       irq_shv_i;
    logic [CLIC_PRIV_W-1:0]     irq_priv_i;
    logic                       irq_ready_o;
    logic                       irq_kill_req_i;
    logic                       irq_kill_ack_o;

    logic                       core_irq_req_o;
    logic [SRC_W-1:0]           core_irq_id_o;
    logic [CLIC_INTCTLBITS-1:0] core_irq_level_o;
    logic                       core_irq_shv_o;
    logic [CLIC_PRIV_W-1:0]     core_irq_priv_o;
    logic                       core_irq_ack_i;

    // master: the CLIC arbiter plus the core; slave: the bridge itself
    modport master (
        output irq_valid_i, irq_id_i, irq_level_i, irq_shv_i, irq_priv_i,
        output irq_kill_req_i, core_irq_ack_i,
        input  irq_ready_o, irq_kill_ack_o,
        input  core_irq_req_o, core_irq_id_o, core_irq_level_o, core_irq_shv_o, core_irq_priv_o
    );

    modport slave (
        input  irq_valid_i, irq_id_i, irq_level_i, irq_shv_i, irq_priv_i,
        input  irq_kill_req_i, core_irq_ack_i,
        output irq_ready_o, irq_kill_ack_o,
        output core_irq_req_o, core_irq_id_o, core_irq_level_o, core_irq_shv_o, core_irq_priv_o
    );
endinterface

// File: rtl/clic_core_bridge_sat_cnt.sv
// Saturating event counter; a clear in the same cycle as an increment wins.
module clic_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;
endmodule

// File: rtl/clic_core_bridge.sv
// Holds one CLIC arbitration winner as a registered request to the core until
// the core takes it or the CLIC withdraws it, then idles one cycle.
module clic_core_bridge
    import clic_core_bridge_pkg::*;
#(
    parameter int N_SOURCE = CLIC_N_SOURCE,
    parameter int SRC_W    = $clog2(N_SOURCE),
    parameter int CNT_W    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       irq_valid_i,
    input  logic [SRC_W-1:0]           irq_id_i,
    input  logic [CLIC_INTCTLBITS-1:0] irq_level_i,
    input  logic                       irq_shv_i,
    input  logic [CLIC_PRIV_W-1:0]     irq_priv_i,
    output logic                       irq_ready_o,
    input  logic                       irq_kill_req_i,
    output logic                       irq_kill_ack_o,
    output logic                       core_irq_req_o,
    output logic [SRC_W-1:0]           core_irq_id_o,
    output logic [CLIC_INTCTLBITS-1:0] core_irq_level_o,
    output logic                       core_irq_shv_o,
    output logic [CLIC_PRIV_W-1:0]     core_irq_priv_o,
    input  logic                       core_irq_ack_i,
    input  logic                       cnt_clr_i,
    output logic [CNT_W-1:0]           taken_cnt_o,
    output logic [CNT_W-1:0]           kill_cnt_o
);
    bridge_state_e              r_state;
    bridge_state_e              w_state_next;
    logic                       w_capture;
    logic                       w_take;
    logic                       w_kill;
    logic                       r_req;
    logic                       r_ready;
    logic                       r_kill_ack;
    logic [SRC_W-1:0]           r_id;
    logic [CLIC_INTCTLBITS-1:0] r_level;
    logic                       r_shv;
    logic [CLIC_PRIV_W-1:0]     r_priv;

    // A simultaneous core ack beats a kill: the core has already trapped.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_take       = 1'b0;
        w_kill       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (irq_valid_i && !irq_kill_req_i) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (core_irq_ack_i) begin
                    w_take       = 1'b1;
                    w_state_next = ST_ACK;
                end else if (irq_kill_req_i) begin
                    w_kill       = 1'b1;
                    w_state_next = ST_KILL;
                end
            end
            ST_ACK, ST_KILL: w_state_next = ST_GAP;
            ST_GAP:          w_state_next = ST_IDLE;
            default:         w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_ready    <= 1'b0;
            r_kill_ack <= 1'b0;
            r_id       <= '0;
            r_level    <= '0;
            r_shv      <= 1'b0;
            r_priv     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_req      <= (w_state_next == ST_PEND);
            r_ready    <= w_take;
            r_kill_ack <= w_kill;
            if (w_capture) begin
                r_id    <= irq_id_i;
                r_level <= irq_level_i;
                r_shv   <= irq_shv_i;
                r_priv  <= irq_priv_i;
            end
        end
    end

    // Counters advance on the same edge that raises the matching pulse.
    clic_sat_cnt #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (w_take),
        .clr    (cnt_clr_i),
        .cnt_o  (taken_cnt_o)
    );

    clic_sat_cnt #(.CNT_W(CNT_W)) u_kill_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (w_kill),
        .clr    (cnt_clr_i),
        .cnt_o  (kill_cnt_o)
    );

    assign irq_ready_o      = r_ready;
    assign irq_kill_ack_o   = r_kill_ack;
    assign core_irq_req_o   = r_req;
    assign core_irq_id_o    = r_id;
    assign core_irq_level_o = r_level;
    assign core_irq_shv_o   = r_shv;
    assign core_irq_priv_o  = r_priv;
endmodule

// File: tb/tb_clic_core_bridge.sv
// Directed scoreboard bench: stimulus queues expected events, a negedge monitor checks them.
module tb_clic_core_bridge;
    localparam int SRC_W   = 8;
    localparam int CNT_W   = 2;
    localparam int K_REQ   = 0;
    localparam int K_READY = 1;
    localparam int K_KILL  = 2;

    typedef struct {
        int         kind;
        logic [7:0] id;
        logic [7:0] lvl;
        logic       shv;
        logic [1:0] priv;
        int         cyc;
        int         taken;
        int         kill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] kill_cnt;
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    exp_t             q[$];
    logic             prev_req = 1'b0;
    logic [7:0]       h_id, h_lvl;
    logic             h_shv;
    logic [1:0]       h_priv;

    clic_core_bridge_if #(.SRC_W(SRC_W)) bus ();

    clic_core_bridge #(.N_SOURCE(256), .SRC_W(SRC_W), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .irq_valid_i      (bus.irq_valid_i),
        .irq_id_i         (bus.irq_id_i),
        .irq_level_i      (bus.irq_level_i),
        .irq_shv_i        (bus.irq_shv_i),
        .irq_priv_i       (bus.irq_priv_i),
        .irq_ready_o      (bus.irq_ready_o),
        .irq_kill_req_i   (bus.irq_kill_req_i),
        .irq_kill_ack_o   (bus.irq_kill_ack_o),
        .core_irq_req_o   (bus.core_irq_req_o),
        .core_irq_id_o    (bus.core_irq_id_o),
        .core_irq_level_o (bus.core_irq_level_o),
        .core_irq_shv_o   (bus.core_irq_shv_o),
        .core_irq_priv_o  (bus.core_irq_priv_o),
        .core_irq_ack_i   (bus.core_irq_ack_i),
        .cnt_clr_i        (cnt_clr),
        .taken_cnt_o      (taken_cnt),
        .kill_cnt_o       (kill_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void push(input int kind, input logic [7:0] id, input logic [7:0] lvl,
                                 input logic shv, input logic [1:0] priv, input int c,
                                 input int t, input int k);
        exp_t e;
        e.kind = kind; e.id = id; e.lvl = lvl; e.shv = shv; e.priv = priv;
        e.cyc = c; e.taken = t; e.kill = k;
        q.push_back(e);
    endfunction

    task automatic pop_expect(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", kind, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                n_fail++;
                $display("FAIL event_kind: got kind %0d at cycle %0d, required kind %0d", kind, cyc, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        check("pulse_exclusive", int'(bus.irq_ready_o & bus.irq_kill_ack_o), 0);
        if (bus.core_irq_req_o && !prev_req) begin
            pop_expect(K_REQ, e, ok);
            $display("[TB] cyc %0d req id=%0d lvl=%0h shv=%0b priv=%0d", cyc,
                     bus.core_irq_id_o, bus.core_irq_level_o, bus.core_irq_shv_o, bus.core_irq_priv_o);
            if (ok) begin
                check("req_cycle", cyc, e.cyc);
                check("req_id", int'(bus.core_irq_id_o), int'(e.id));
                check("req_level", int'(bus.core_irq_level_o), int'(e.lvl));
                check("req_shv", int'(bus.core_irq_shv_o), int'(e.shv));
                check("req_priv", int'(bus.core_irq_priv_o), int'(e.priv));
            end
            h_id = e.id; h_lvl = e.lvl; h_shv = e.shv; h_priv = e.priv;
        end else if (bus.core_irq_req_o) begin
            check("hold_id", int'(bus.core_irq_id_o), int'(h_id));
            check("hold_level", int'(bus.core_irq_level_o), int'(h_lvl));
            check("hold_shv_priv", int'({bus.core_irq_shv_o, bus.core_irq_priv_o}), int'({h_shv, h_priv}));
        end
        if (bus.irq_ready_o) begin
            pop_expect(K_READY, e, ok);
            $display("[TB] cyc %0d ready taken=%0d kill=%0d", cyc, taken_cnt, kill_cnt);
            if (ok) begin
                check("ready_cycle", cyc, e.cyc);
                check("ready_taken_cnt", int'(taken_cnt), e.taken);
                check("ready_kill_cnt", int'(kill_cnt), e.kill);
                check("ready_req_low", int'(bus.core_irq_req_o), 0);
            end
        end
        if (bus.irq_kill_ack_o) begin
            pop_expect(K_KILL, e, ok);
            $display("[TB] cyc %0d kill_ack taken=%0d kill=%0d", cyc, taken_cnt, kill_cnt);
            if (ok) begin
                check("kill_cycle", cyc, e.cyc);
                check("kill_taken_cnt", int'(taken_cnt), e.taken);
                check("kill_kill_cnt", int'(kill_cnt), e.kill);
                check("kill_req_low", int'(bus.core_irq_req_o), 0);
            end
        end
        prev_req <= bus.core_irq_req_o;
    end

    // lead: edges until capture; chain: return in the ACK/KILL cycle instead of back in IDLE
    task automatic serve(input logic [7:0] id, input logic [7:0] lvl, input logic shv,
                         input logic [1:0] priv, input int lead, input int hold,
                         input logic [7:0] chg_id, input bit do_ack, input bit do_kill,
                         input bit do_clr, input int exp_taken, input int exp_kill, input bit chain);
        push(K_REQ, id, lvl, shv, priv, cyc + lead, 0, 0);
        bus.irq_valid_i = 1'b1;
        bus.irq_id_i    = id;
        bus.irq_level_i = lvl;
        bus.irq_shv_i   = shv;
        bus.irq_priv_i  = priv;
        repeat (lead) begin @(posedge clk); #1; end
        for (int i = 0; i < hold; i++) begin
            bus.irq_id_i    = chg_id;
            bus.irq_level_i = ~lvl;
            bus.irq_shv_i   = ~shv;
            @(posedge clk); #1;
        end
        bus.irq_valid_i    = 1'b0;
        bus.core_irq_ack_i = do_ack;
        bus.irq_kill_req_i = do_kill;
        cnt_clr            = do_clr;
        push(do_ack ? K_READY : K_KILL, id, lvl, shv, priv, cyc + 1, exp_taken, exp_kill);
        @(posedge clk); #1;
        bus.core_irq_ack_i = 1'b0;
        bus.irq_kill_req_i = 1'b0;
        cnt_clr            = 1'b0;
        if (!chain) repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, int'(bus.core_irq_req_o), 0);
        check({tag, "_id"}, int'(bus.core_irq_id_o), 0);
        check({tag, "_level"}, int'(bus.core_irq_level_o), 0);
        check({tag, "_shv"}, int'(bus.core_irq_shv_o), 0);
        check({tag, "_priv"}, int'(bus.core_irq_priv_o), 0);
        check({tag, "_ready"}, int'(bus.irq_ready_o), 0);
        check({tag, "_kill_ack"}, int'(bus.irq_kill_ack_o), 0);
        check({tag, "_taken_cnt"}, int'(taken_cnt), 0);
        check({tag, "_kill_cnt"}, int'(kill_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.irq_valid_i    = 1'b0;
        bus.irq_id_i       = '0;
        bus.irq_level_i    = '0;
        bus.irq_shv_i      = 1'b0;
        bus.irq_priv_i     = '0;
        bus.irq_kill_req_i = 1'b0;
        bus.core_irq_ack_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check_all_zero("reset");
        #3 rst_n = 1'b1;

        // take, captured on the first edge after reset release
        serve(8'd5, 8'h80, 1'b1, 2'd3, 1, 0, 8'd0, 1, 0, 0, 1, 0, 0);
        // kill id 7, then id 9 presented during KILL/GAP is captured only from IDLE
        serve(8'd7, 8'h40, 1'b0, 2'd1, 1, 0, 8'd0, 0, 1, 0, 1, 1, 1);
        serve(8'd9, 8'h20, 1'b1, 2'd0, 3, 0, 8'd0, 1, 0, 0, 2, 1, 0);
        // ack and kill together: the ack wins
        serve(8'd3, 8'h10, 1'b0, 2'd2, 1, 0, 8'd0, 1, 1, 0, 3, 1, 0);
        // CLIC winner changes 5 -> 12 while pending; counter saturates at 3
        serve(8'd5, 8'h80, 1'b0, 2'd3, 1, 3, 8'd12, 1, 0, 0, 3, 1, 0);
        serve(8'd1, 8'hff, 1'b1, 2'd1, 1, 0, 8'd0, 1, 0, 0, 3, 1, 0);

        // kill with valid, then ack and kill alone, all in IDLE: no events
        bus.irq_valid_i    = 1'b1;
        bus.irq_id_i       = 8'h55;
        bus.irq_kill_req_i = 1'b1;
        @(posedge clk); #1;
        bus.irq_valid_i    = 1'b0;
        bus.irq_kill_req_i = 1'b0;
        bus.core_irq_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.core_irq_ack_i = 1'b0;
        bus.irq_kill_req_i = 1'b1;
        @(posedge clk); #1;
        bus.irq_kill_req_i = 1'b0;
        @(posedge clk); #1;
        check("idle_no_req", int'(bus.core_irq_req_o), 0);
        check("idle_taken_cnt", int'(taken_cnt), 3);
        check("idle_kill_cnt", int'(kill_cnt), 1);

        // clear together with an ack: both counters read 0
        serve(8'd2, 8'h01, 1'b0, 2'd0, 1, 0, 8'd0, 1, 0, 1, 0, 0, 0);
        serve(8'd10, 8'h02, 1'b1, 2'd2, 1, 0, 8'd0, 0, 1, 0, 0, 1, 0);

        // reset while pending, with ack and kill held during reset
        push(K_REQ, 8'd4, 8'h33, 1'b1, 2'd1, cyc + 1, 0, 0);
        bus.irq_valid_i = 1'b1;
        bus.irq_id_i    = 8'd4;
        bus.irq_level_i = 8'h33;
        bus.irq_shv_i   = 1'b1;
        bus.irq_priv_i  = 2'd1;
        @(posedge clk); #1;
        bus.irq_valid_i = 1'b0;
        @(negedge clk); #1;
        rst_n              = 1'b0;
        bus.core_irq_ack_i = 1'b1;
        bus.irq_kill_req_i = 1'b1;
        #1;
        check_all_zero("midpend_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.core_irq_ack_i = 1'b0;
        bus.irq_kill_req_i = 1'b0;
        #3 rst_n = 1'b1;
        serve(8'd6, 8'h44, 1'b0, 2'd2, 1, 0, 8'd0, 1, 0, 0, 1, 0, 0);

        repeat (3) begin @(posedge clk); #1; end
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
